// File: rtl/flappy_pkg.sv
// Shared Flappy constants and the one-hot game state encoding, used by the
// game controller, pipe mover and renderer.
package flappy_pkg;

    typedef enum logic [3:0] {
        START_SCREEN = 4'b0001,
        IN_GAME      = 4'b0010,
        PAUSE        = 4'b0100,
        END_SCREEN   = 4'b1000
    } game_state_t;

    localparam int NUM_PIPES   = 4;
    localparam int PIPE_SIZE_X = 78;
    localparam int GAP_SIZE    = 128;
    localparam int BIRD_SIZE   = 32;
    localparam int PLAY_HEIGHT = 420;

    localparam int PIPE_IDX_W  = $clog2(NUM_PIPES);
    localparam int SCAN_IDX_W  = $clog2(NUM_PIPES + 1);

endpackage

// File: rtl/pipe_hit_check.sv
// Combinational bird-vs-pipe test: hit when the boxes overlap in x and the
// bird is not fully inside the vertical gap. Touching edges do not count.
module pipe_hit_check
    import flappy_pkg::*;
(
    input  logic signed [31:0] bird_x,
    input  logic signed [31:0] bird_y,
    input  logic signed [31:0] pipe_x,
    input  logic signed [31:0] pipe_y,
    output logic               hit
);

    logic x_overlap;
    logic outside_gap;

    // NOTE: every variable is assigned on every path through this block, so no latch is inferred.
    always_comb begin
        x_overlap   = (bird_x < pipe_x + PIPE_SIZE_X) && (bird_x + BIRD_SIZE > pipe_x);
        outside_gap = (bird_y < pipe_y) || (bird_y + BIRD_SIZE > pipe_y + GAP_SIZE);
        hit         = x_overlap && outside_gap;
    end

endmodule

// File: rtl/game_controller.sv
// Flappy top-level game FSM with a per-frame serial collision scan (one pipe per
// cycle, then the floor). Define CEILING_COLLISION_EN to make birdY < 0 a hit.
module game_controller
    import flappy_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_tick,
    input  logic               key_start,
    input  logic               key_pause,
    input  logic        [31:0] birdX,
    input  logic signed [31:0] birdY,
    input  logic signed [31:0] pipeX_1,
    input  logic signed [31:0] pipeX_2,
    input  logic signed [31:0] pipeX_3,
    input  logic signed [31:0] pipeX_4,
    input  logic        [31:0] pipeY_1,
    input  logic        [31:0] pipeY_2,
    input  logic        [31:0] pipeY_3,
    input  logic        [31:0] pipeY_4,
    input  logic        [31:0] score_count,
    output logic         [3:0] game_state,
    output logic               collision,
    output logic        [31:0] high_score
);

    game_state_t           state;
    logic                  start_q;
    logic                  pause_q;
    logic                  scan_busy;
    logic [SCAN_IDX_W-1:0] scan_idx;
    logic                  hit_acc;

    logic                  start_edge;
    logic                  pause_edge;
    logic                  scan_last;
    logic                  pipe_hit;
    logic                  floor_hit;
    logic                  ceiling_hit;
    logic                  frame_hit;
    logic [PIPE_IDX_W-1:0] pipe_sel;
    logic signed [31:0]    pipe_x_arr [NUM_PIPES];
    logic signed [31:0]    pipe_y_arr [NUM_PIPES];

    assign start_edge = key_start & ~start_q;
    assign pause_edge = key_pause & ~pause_q;

    assign pipe_x_arr[0] = pipeX_1;
    assign pipe_x_arr[1] = pipeX_2;
    assign pipe_x_arr[2] = pipeX_3;
    assign pipe_x_arr[3] = pipeX_4;
    assign pipe_y_arr[0] = pipeY_1;
    assign pipe_y_arr[1] = pipeY_2;
    assign pipe_y_arr[2] = pipeY_3;
    assign pipe_y_arr[3] = pipeY_4;

    // One checker shared by all pipes; the scan index selects which pipe it sees.
    assign pipe_sel  = scan_idx[PIPE_IDX_W-1:0];
    assign scan_last = (scan_idx == SCAN_IDX_W'(NUM_PIPES));

    pipe_hit_check u_pipe_hit_check (
        .bird_x (birdX),
        .bird_y (birdY),
        .pipe_x (pipe_x_arr[pipe_sel]),
        .pipe_y (pipe_y_arr[pipe_sel]),
        .hit    (pipe_hit)
    );

    assign floor_hit = (birdY + BIRD_SIZE) >= PLAY_HEIGHT;

`ifdef CEILING_COLLISION_EN
    assign ceiling_hit = birdY[31];
`else
    assign ceiling_hit = 1'b0;
`endif

    assign frame_hit  = hit_acc | floor_hit | ceiling_hit;
    assign game_state = state;

    // NOTE: sequential state uses <= so every branch reads the pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= START_SCREEN;
            collision  <= 1'b0;
            high_score <= '0;
            start_q    <= 1'b0;
            pause_q    <= 1'b0;
            scan_busy  <= 1'b0;
            scan_idx   <= '0;
            hit_acc    <= 1'b0;
        end else begin
            start_q <= key_start;
            pause_q <= key_pause;
            unique case (state)
                START_SCREEN: begin
                    if (start_edge) begin
                        state     <= IN_GAME;
                        collision <= 1'b0;
                    end
                end
                IN_GAME: begin
                    if (scan_busy && scan_last) begin
                        // Resolve cycle: a hit outranks a pause arriving on the same edge.
                        scan_busy <= 1'b0;
                        if (frame_hit) begin
                            state     <= END_SCREEN;
                            collision <= 1'b1;
                            if (score_count > high_score)
                                high_score <= score_count;
                        end else if (pause_edge) begin
                            state <= PAUSE;
                        end
                    end else if (pause_edge) begin
                        state     <= PAUSE;
                        scan_busy <= 1'b0;
                    end else if (scan_busy) begin
                        hit_acc  <= hit_acc | pipe_hit;
                        scan_idx <= scan_idx + 1'b1;
                    end else if (frame_tick) begin
                        scan_busy <= 1'b1;
                        scan_idx  <= '0;
                        hit_acc   <= 1'b0;
                    end
                end
                PAUSE: begin
                    if (pause_edge)
                        state <= IN_GAME;
                end
                END_SCREEN: begin
                    if (start_edge)
                        state <= START_SCREEN;
                end
                default: state <= START_SCREEN;
            endcase
        end
    end

endmodule
